// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace serializer.
package wb_trace_pkg;

  // Storage widths of a queued entry. The top level's PC_W/DATA_W must not exceed them.
  localparam int WB_PC_W   = 32;
  localparam int WB_DATA_W = 32;

  // Value driven on the debug byte-enable bus for a register-writing entry.
  localparam logic [3:0] TRACE_WEN_ALL = 4'hf;

  typedef struct packed {
    logic [WB_PC_W-1:0]   pc;
    logic [4:0]           rd;
    logic [WB_DATA_W-1:0] data;
    logic                 wen;
  } wb_entry_t;

endpackage

// File: rtl/wb_trace_fifo2w1r.sv
// Circular queue of wb_entry_t: up to two pushes and one pop per cycle.
// The head is popped every cycle the queue is non-empty (the sink never stalls).
// The caller must keep i_n_push <= o_free.
module wb_trace_fifo2w1r
  import wb_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    i_n_push,
  input  wb_entry_t     i_e0,
  input  wb_entry_t     i_e1,
  output wb_entry_t     o_head,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_free
);

  wb_entry_t         r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              w_pop;

  assign w_pop   = (r_count != '0);
  assign o_head  = r_mem[r_head];
  assign o_count = r_count;
  // The pop happening this cycle releases its slot to the pushes of the same cycle.
  assign o_free  = CW'(DEPTH) - r_count + CW'(w_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) r_head <= r_head + AW'(1);
      r_tail  <= r_tail + AW'(i_n_push);
      r_count <= r_count + CW'(i_n_push) - CW'(w_pop);
    end
  end

  // Entry storage: first push at tail, second right behind it.
  always_ff @(posedge clock) begin
    if (i_n_push != 2'd0) r_mem[r_tail] <= i_e0;
    if (i_n_push == 2'd2) r_mem[r_tail + AW'(1)] <= i_e1;
  end

endmodule

// File: rtl/wb_trace_serializer.sv
// Serializes the two writeback channels onto the single debug trace port,
// keeps the sticky drop flag and the retired-instruction counter.
module wb_trace_serializer
  import wb_trace_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int PC_W           = 32,
  parameter int DATA_W         = 32,
  parameter bit FILTER_NOWRITE = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb0_valid,
  input  logic              wb0_wen,
  input  logic [4:0]        wb0_rd,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic [PC_W-1:0]   wb0_pc,
  input  logic              wb1_valid,
  input  logic              wb1_wen,
  input  logic [4:0]        wb1_rd,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic [PC_W-1:0]   wb1_pc,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata,
  output logic              stall_req,
  output logic              overflow,
  output logic [31:0]       commit_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          w_acc0, w_acc1, w_drop, w_nonempty;
  logic [1:0]    w_req, w_take;
  logic [CW-1:0] w_count, w_free;
  wb_entry_t     w_e0, w_e1, w_first, w_head;
  logic          r_overflow;
  logic [31:0]   r_commit_cnt;

  // A slot is queued if it retires and (when filtering) really writes a non-zero register.
  assign w_acc0 = wb0_valid && (!FILTER_NOWRITE || (wb0_wen && wb0_rd != 5'd0));
  assign w_acc1 = wb1_valid && (!FILTER_NOWRITE || (wb1_wen && wb1_rd != 5'd0));
  assign w_req  = {1'b0, w_acc0} + {1'b0, w_acc1};

  // free is never below 1 (a full queue always pops), so only a 2-push can overflow;
  // slot0 is older and wins the last slot.
  assign w_drop = (w_req == 2'd2) && (w_free < CW'(2));
  assign w_take = w_drop ? 2'd1 : w_req;

  assign w_e0    = '{pc: WB_PC_W'(wb0_pc), rd: wb0_rd, data: WB_DATA_W'(wb0_data), wen: wb0_wen};
  assign w_e1    = '{pc: WB_PC_W'(wb1_pc), rd: wb1_rd, data: WB_DATA_W'(wb1_data), wen: wb1_wen};
  // Compact accepted slots so a lone slot1 lands at the tail.
  assign w_first = w_acc0 ? w_e0 : w_e1;

  wb_trace_fifo2w1r #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .i_n_push (w_take),
    .i_e0     (w_first),
    .i_e1     (w_e1),
    .o_head   (w_head),
    .o_count  (w_count),
    .o_free   (w_free)
  );

  assign w_nonempty        = (w_count != '0);
  assign debug_wb_pc       = w_nonempty ? PC_W'(w_head.pc) : '0;
  assign debug_wb_rf_wen   = (w_nonempty && w_head.wen) ? TRACE_WEN_ALL : 4'h0;
  assign debug_wb_rf_wnum  = w_nonempty ? w_head.rd : 5'd0;
  assign debug_wb_rf_wdata = w_nonempty ? DATA_W'(w_head.data) : '0;
  assign stall_req         = (CW'(DEPTH) - w_count) < CW'(2);
  assign overflow          = r_overflow;
  assign commit_cnt        = r_commit_cnt;

  // Sticky drop flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  // Every retiring slot counts, whether or not it was traced.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_commit_cnt <= '0;
    else       r_commit_cnt <= r_commit_cnt + 32'(wb0_valid) + 32'(wb1_valid);
  end

endmodule

// File: tb/tb_wb_trace_serializer.sv
// Directed bench: a queue-level reference model checked every cycle, plus literal spot checks.
module tb_wb_trace_serializer;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb0_valid = 0, wb0_wen = 0, wb1_valid = 0, wb1_wen = 0;
  logic [4:0]  wb0_rd = 0, wb1_rd = 0;
  logic [31:0] wb0_data = 0, wb0_pc = 0, wb1_data = 0, wb1_pc = 0;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata, commit_cnt;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic        stall_req, overflow;

  int total = 0;
  int bad   = 0;

  wb_trace_serializer #(.DEPTH(DEPTH), .PC_W(32), .DATA_W(32), .FILTER_NOWRITE(1'b1)) dut (
    .clock(clock), .reset(reset),
    .wb0_valid(wb0_valid), .wb0_wen(wb0_wen), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_pc(wb0_pc),
    .wb1_valid(wb1_valid), .wb1_wen(wb1_wen), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_pc(wb1_pc),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .stall_req(stall_req), .overflow(overflow),
    .commit_cnt(commit_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: a plain queue of traced writes.
  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wen;
  } m_t;

  m_t          mq[$];
  logic        movf = 1'b0;
  logic [31:0] mcnt = 32'd0;

  function automatic bit traced(input logic v, input logic w, input logic [4:0] r);
    return v && w && (r != 5'd0);
  endfunction

  // Each edge: the head leaves, then slot0 and slot1 enter while there is room.
  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        mq.delete();
        movf = 1'b0;
        mcnt = 32'd0;
      end else begin
        m_t e;
        if (mq.size() > 0) void'(mq.pop_front());
        if (traced(wb0_valid, wb0_wen, wb0_rd)) begin
          e.pc = wb0_pc; e.rd = wb0_rd; e.data = wb0_data; e.wen = wb0_wen;
          if (mq.size() < DEPTH) mq.push_back(e); else movf = 1'b1;
        end
        if (traced(wb1_valid, wb1_wen, wb1_rd)) begin
          e.pc = wb1_pc; e.rd = wb1_rd; e.data = wb1_data; e.wen = wb1_wen;
          if (mq.size() < DEPTH) mq.push_back(e); else movf = 1'b1;
        end
        mcnt = mcnt + 32'(wb0_valid) + 32'(wb1_valid);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (mq.size() > 0) begin
          chk("cmp_pc",    debug_wb_pc,       mq[0].pc);
          chk("cmp_wen",   debug_wb_rf_wen,   mq[0].wen ? 4'hf : 4'h0);
          chk("cmp_wnum",  debug_wb_rf_wnum,  mq[0].rd);
          chk("cmp_wdata", debug_wb_rf_wdata, mq[0].data);
        end else begin
          chk("cmp_pc0",   debug_wb_pc,       0);
          chk("cmp_wen0",  debug_wb_rf_wen,   0);
          chk("cmp_wnum0", debug_wb_rf_wnum,  0);
          chk("cmp_wdat0", debug_wb_rf_wdata, 0);
        end
        chk("cmp_stall", stall_req,  (DEPTH - mq.size()) < 2);
        chk("cmp_ovf",   overflow,   movf);
        chk("cmp_cnt",   commit_cnt, mcnt);
      end
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic drive(input logic v0, input logic w0, input logic [4:0] r0, input logic [31:0] d0,
                       input logic [31:0] p0, input logic v1, input logic w1, input logic [4:0] r1,
                       input logic [31:0] d1, input logic [31:0] p1);
    wb0_valid = v0; wb0_wen = w0; wb0_rd = r0; wb0_data = d0; wb0_pc = p0;
    wb1_valid = v1; wb1_wen = w1; wb1_rd = r1; wb1_data = d1; wb1_pc = p1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic dual(input logic [31:0] pc, input logic [4:0] rd);
    drive(1, 1, rd, pc ^ 32'h5a5a_0000, pc, 1, 1, rd + 5'd1, (pc + 4) ^ 32'h5a5a_0000, pc + 4);
  endtask

  initial begin
    logic [31:0] c0;
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pc", debug_wb_pc, 0);
    chk("rst_wen", debug_wb_rf_wen, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_cnt", commit_cnt, 0);
    reset = 1'b0;
    idle();

    // 1: four dual pushes, one entry out per cycle in program order
    for (int i = 0; i < 4; i++) begin
      dual(32'hbfc0_0000 + 32'(8 * i), 5'(2 * i + 1));
      chk("t1_pc", debug_wb_pc, 32'hbfc0_0000 + 32'(4 * i));
    end
    for (int i = 4; i < 8; i++) begin
      idle();
      chk("t1_pc", debug_wb_pc, 32'hbfc0_0000 + 32'(4 * i));
    end
    chk("t1_wnum", debug_wb_rf_wnum, 8);
    idle();
    chk("t1_empty", debug_wb_pc, 0);

    // 2: slot0 writes x0 and is filtered; only slot1 is traced
    c0 = commit_cnt;
    drive(1, 1, 0, 32'h1111, 32'hbfc0_0040, 1, 1, 5, 32'h2222, 32'hbfc0_0044);
    chk("t2_pc", debug_wb_pc, 32'hbfc0_0044);
    chk("t2_wnum", debug_wb_rf_wnum, 5);
    chk("t2_cnt", commit_cnt, c0 + 2);
    idle();
    chk("t2_empty", debug_wb_pc, 0);

    // 3: slot1-only push into an empty queue
    drive(0, 0, 0, 0, 0, 1, 1, 3, 32'hdead_beef, 32'hbfc0_0100);
    chk("t3_wen", debug_wb_rf_wen, 4'hf);
    chk("t3_wdata", debug_wb_rf_wdata, 32'hdead_beef);
    chk("t3_pc", debug_wb_pc, 32'hbfc0_0100);
    idle();
    chk("t3_z_pc", debug_wb_pc, 0);
    chk("t3_z_wen", debug_wb_rf_wen, 0);
    chk("t3_z_wdata", debug_wb_rf_wdata, 0);

    // 4: fill to 8, then a dual push with no room for slot1
    chk("t4_ovf0", overflow, 0);
    for (int i = 0; i < 7; i++) begin
      dual(32'hbfc0_1000 + 32'(8 * i), 5'(i + 1));
      if (i == 4) chk("t4_stall_c6", stall_req, 0);
      if (i == 5) chk("t4_stall_c7", stall_req, 1);
    end
    dual(32'hbfc0_2000, 5'd9);
    chk("t4_ovf", overflow, 1);
    chk("t4_stall", stall_req, 1);
    for (int i = 0; i < 7; i++) idle();
    chk("t4_last_pc", debug_wb_pc, 32'hbfc0_2000);
    idle();
    chk("t4_drained", debug_wb_rf_wen, 0);
    chk("t4_ovf_held", overflow, 1);

    // 5: asynchronous reset with entries queued
    dual(32'hbfc0_3000, 5'd1);
    dual(32'hbfc0_3008, 5'd3);
    #2 reset = 1'b1;
    #1;
    chk("t5_pc", debug_wb_pc, 0);
    chk("t5_wen", debug_wb_rf_wen, 0);
    chk("t5_stall", stall_req, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_cnt", commit_cnt, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    idle();
    chk("t5_after", debug_wb_pc, 0);

    // 6: commit counter wrap
    mcnt = 32'hffff_ffff;
    force dut.r_commit_cnt = 32'hffff_ffff;
    #1;
    release dut.r_commit_cnt;
    drive(1, 0, 0, 0, 32'hbfc0_4000, 1, 0, 0, 0, 32'hbfc0_4004);
    chk("t6_wrap", commit_cnt, 32'h0000_0001);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
